// File: rtl/dcp_fog_synth.sv
// Forward haze model I = (J*t + A*(255-t)) / 255 per channel, 3-cycle pipeline,
// with per-frame atmospheric-light latch and valid-pixel counter. Build macro: FOG_ROUND_EN.
`timescale 1ns/1ps

module dcp_fog_synth #(
    parameter logic [23:0] AIR_DEFAULT = 24'hF0F0F0,
    parameter int          CNT_W       = 22
) (
    input  logic             pixelclk,
    input  logic             reset,
    input  logic [23:0]      i_rgb,
    input  logic [7:0]       i_transmittance,
    input  logic [23:0]      i_air_light,
    input  logic             i_hsync,
    input  logic             i_vsync,
    input  logic             i_data_valid,
    output logic [23:0]      o_fog_rgb,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_data_valid,
    output logic [23:0]      o_air_light,
    output logic [CNT_W-1:0] o_frame_pix_cnt
);

`ifdef FOG_ROUND_EN
    localparam logic [16:0] RND = 17'd127;
`else
    localparam logic [16:0] RND = 17'd0;
`endif

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [23:0]       j_q, j_d;
    logic [7:0]        t_q, t_d;
    logic [7:0]        nt_q, nt_d;
    logic [23:0]       a1_q, a1_d;
    logic [23:0]       air_q, air_d;
    logic [2:0][15:0]  p_q, p_d;
    logic [2:0][15:0]  qa_q, qa_d;
    logic [23:0]       fog_q, fog_d;
    logic [2:0]        hs_q, hs_d;
    logic [2:0]        vs_q, vs_d;
    logic [2:0]        dv_q, dv_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  frm_q, frm_d;
    logic              vsync_rise;
    logic [16:0]       sum;

    // vs_q[0] doubles as the registered vsync used for edge detection
    assign vsync_rise = i_vsync & ~vs_q[0];

    always_comb begin
        j_d   = i_rgb;
        t_d   = i_transmittance;
        nt_d  = 8'd255 - i_transmittance;
        a1_d  = air_q;
        air_d = air_q;
        p_d   = p_q;
        qa_d  = qa_q;
        fog_d = fog_q;
        sum   = 17'd0;
        hs_d  = {hs_q[1:0], i_hsync};
        vs_d  = {vs_q[1:0], i_vsync};
        dv_d  = {dv_q[1:0], i_data_valid};
        cnt_d = cnt_q;
        frm_d = frm_q;

        // The pixel sampled on the rise cycle still takes the old A via a1_d
        if (vsync_rise) begin
            air_d = i_air_light;
        end

        for (int c = 0; c < 3; c++) begin
            p_d[c]  = {8'd0, j_q[c*8 +: 8]} * {8'd0, t_q};
            qa_d[c] = {8'd0, a1_q[c*8 +: 8]} * {8'd0, nt_q};
            sum     = {1'b0, p_q[c]} + {1'b0, qa_q[c]} + RND;
            fog_d[c*8 +: 8] = 8'(sum / 17'd255);
        end

        if (vsync_rise) begin
            frm_d = cnt_q;
            cnt_d = i_data_valid ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
        end else if (i_data_valid && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge pixelclk) begin
        if (reset) begin
            j_q   <= '0;
            t_q   <= '0;
            nt_q  <= '0;
            a1_q  <= '0;
            air_q <= AIR_DEFAULT;
            p_q   <= '0;
            qa_q  <= '0;
            fog_q <= '0;
            hs_q  <= '0;
            vs_q  <= '0;
            dv_q  <= '0;
            cnt_q <= '0;
            frm_q <= '0;
        end else begin
            j_q   <= j_d;
            t_q   <= t_d;
            nt_q  <= nt_d;
            a1_q  <= a1_d;
            air_q <= air_d;
            p_q   <= p_d;
            qa_q  <= qa_d;
            fog_q <= fog_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            dv_q  <= dv_d;
            cnt_q <= cnt_d;
            frm_q <= frm_d;
        end
    end

    assign o_fog_rgb       = fog_q;
    assign o_hsync         = hs_q[2];
    assign o_vsync         = vs_q[2];
    assign o_data_valid    = dv_q[2];
    assign o_air_light     = air_q;
    assign o_frame_pix_cnt = frm_q;

endmodule

// File: tb/tb_dcp_fog_synth.sv
// Bench for dcp_fog_synth: constant vector table, hand sequences for air-light,
// frame counter and reset corners, then random traffic against a queue-based reference model.
`timescale 1ns/1ps

module tb_dcp_fog_synth;

    localparam logic [23:0] AIR_DEF = 24'hF0F0F0;
    localparam int          CNT_W   = 22;
`ifdef FOG_ROUND_EN
    localparam int          RND     = 127;
    localparam logic [23:0] EXP_MID = 24'hDCAA78;
`else
    localparam int          RND     = 0;
    localparam logic [23:0] EXP_MID = 24'hDBA977;
`endif

    logic             pixelclk;
    logic             reset;
    logic [23:0]      i_rgb;
    logic [7:0]       i_transmittance;
    logic [23:0]      i_air_light;
    logic             i_hsync;
    logic             i_vsync;
    logic             i_data_valid;
    logic [23:0]      o_fog_rgb;
    logic             o_hsync;
    logic             o_vsync;
    logic             o_data_valid;
    logic [23:0]      o_air_light;
    logic [CNT_W-1:0] o_frame_pix_cnt;

    dcp_fog_synth #(.AIR_DEFAULT(AIR_DEF), .CNT_W(CNT_W)) dut (
        .pixelclk        (pixelclk),
        .reset           (reset),
        .i_rgb           (i_rgb),
        .i_transmittance (i_transmittance),
        .i_air_light     (i_air_light),
        .i_hsync         (i_hsync),
        .i_vsync         (i_vsync),
        .i_data_valid    (i_data_valid),
        .o_fog_rgb       (o_fog_rgb),
        .o_hsync         (o_hsync),
        .o_vsync         (o_vsync),
        .o_data_valid    (o_data_valid),
        .o_air_light     (o_air_light),
        .o_frame_pix_cnt (o_frame_pix_cnt)
    );

    initial pixelclk = 1'b0;
    always #5 pixelclk = ~pixelclk;

    typedef struct {
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        dv;
    } exp_t;

    typedef struct {
        logic [23:0] j;
        logic [7:0]  t;
        logic [23:0] e;
    } vec_t;

    exp_t        exp_q[$];
    vec_t        vecs[8];
    int          n_cmp;
    int          n_bad;
    logic [23:0] air_m;
    logic        prev_vs;
    int          cnt_m;
    int          frame_m;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] fog(input logic [23:0] j, input logic [7:0] t,
                                        input logic [23:0] a);
        logic [23:0] r;
        int jj, aa, tt;
        r  = '0;
        tt = int'(t);
        for (int c = 0; c < 3; c++) begin
            jj = int'(j[c*8 +: 8]);
            aa = int'(a[c*8 +: 8]);
            r[c*8 +: 8] = 8'((jj * tt + aa * (255 - tt) + RND) / 255);
        end
        return r;
    endfunction

    // One clock: drive inputs, advance the reference model, then check outputs after the edge.
    task automatic cyc(input logic rst, input logic [23:0] rgb, input logic [7:0] t,
                       input logic [23:0] air, input logic hs, input logic vs, input logic dv,
                       input logic ovr, input logic [23:0] ovr_rgb);
        exp_t e;
        reset           = rst;
        i_rgb           = rgb;
        i_transmittance = t;
        i_air_light     = air;
        i_hsync         = hs;
        i_vsync         = vs;
        i_data_valid    = dv;
        if (rst) begin
            exp_q.delete();
            e.rgb = '0; e.hs = 1'b0; e.vs = 1'b0; e.dv = 1'b0;
            repeat (3) exp_q.push_back(e);
            air_m   = AIR_DEF;
            prev_vs = 1'b0;
            cnt_m   = 0;
            frame_m = 0;
        end else begin
            e.rgb = ovr ? ovr_rgb : fog(rgb, t, air_m);
            e.hs  = hs;
            e.vs  = vs;
            e.dv  = dv;
            exp_q.push_back(e);
            if (vs && !prev_vs) begin
                frame_m = cnt_m;
                cnt_m   = dv ? 1 : 0;
                air_m   = air;
            end else if (dv && cnt_m < (1 << CNT_W) - 1) begin
                cnt_m++;
            end
            prev_vs = vs;
        end
        @(posedge pixelclk);
        #1;
        if (exp_q.size() == 3) begin
            e = exp_q.pop_front();
            chk("sync_valid", 32'({o_hsync, o_vsync, o_data_valid}), 32'({e.hs, e.vs, e.dv}));
            if (e.dv) chk("fog_rgb", 32'(o_fog_rgb), 32'(e.rgb));
        end else begin
            n_cmp++;
            n_bad++;
            $display("FAIL pipe_model: queue depth %0d expected 3", exp_q.size());
        end
        chk("air_light", 32'(o_air_light), 32'(air_m));
        chk("frame_cnt", 32'(o_frame_pix_cnt), 32'(frame_m));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 24'h0, 8'h0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic vs_r;
        logic [7:0] t_r;
        n_cmp = 0;
        n_bad = 0;

        vecs[0] = '{j: 24'hC86400, t: 8'd255, e: 24'hC86400};
        vecs[1] = '{j: 24'hC86400, t: 8'd0,   e: 24'hF0F0F0};
        vecs[2] = '{j: 24'hC86400, t: 8'd128, e: EXP_MID};
        vecs[3] = '{j: 24'hF0F0F0, t: 8'd77,  e: 24'hF0F0F0};
        vecs[4] = '{j: 24'h000000, t: 8'd0,   e: 24'hF0F0F0};
        vecs[5] = '{j: 24'hFFFFFF, t: 8'd255, e: 24'hFFFFFF};
        vecs[6] = '{j: 24'h000000, t: 8'd255, e: 24'h000000};
        vecs[7] = '{j: 24'h123456, t: 8'd1,   e: 24'hEFEFEF};

        cyc(1'b1, 24'h0, 8'h0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
        cyc(1'b1, 24'h0, 8'h0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
        chk("rst_fog", 32'(o_fog_rgb), 32'h0);
        chk("rst_air", 32'(o_air_light), 32'(AIR_DEF));
        chk("rst_cnt", 32'(o_frame_pix_cnt), 32'h0);

        // Constant vectors; i_air_light is ignored without a vsync rise
        for (int i = 0; i < 8; i++)
            cyc(1'b0, vecs[i].j, vecs[i].t, 24'h123456, 1'b0, 1'b0, 1'b1, 1'b1, vecs[i].e);
        idle(3);

        // Air-light: a change during a frame is ignored, latched only on the rise
        cyc(1'b0, 24'hC86400, 8'd0, 24'hF0F0F0, 1'b0, 1'b1, 1'b1, 1'b1, 24'hF0F0F0);
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 24'hC86400, 8'd0, 24'h808080, 1'b0, 1'b1, 1'b1, 1'b1, 24'hF0F0F0);
        chk("air_ignored", 32'(o_air_light), 32'hF0F0F0);
        cyc(1'b0, 24'h0, 8'd0, 24'h808080, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
        cyc(1'b0, 24'h0, 8'd0, 24'h808080, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
        cyc(1'b0, 24'hC86400, 8'd0, 24'h808080, 1'b1, 1'b1, 1'b1, 1'b1, 24'hF0F0F0);
        chk("air_latched", 32'(o_air_light), 32'h808080);
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 24'hC86400, 8'd0, 24'h000000, 1'b0, 1'b1, 1'b1, 1'b1, 24'h808080);
        idle(3);

        // Reset with two pixels in flight: both are dropped, A returns to default
        cyc(1'b0, 24'h112233, 8'd100, 24'h0, 1'b1, 1'b1, 1'b1, 1'b0, 24'h0);
        cyc(1'b0, 24'h445566, 8'd200, 24'h0, 1'b1, 1'b1, 1'b1, 1'b0, 24'h0);
        cyc(1'b1, 24'h778899, 8'd50,  24'h0, 1'b1, 1'b1, 1'b1, 1'b0, 24'h0);
        chk("rst_flight_air", 32'(o_air_light), 32'hF0F0F0);
        for (int i = 0; i < 2; i++) begin
            chk("rst_flight_dv", 32'(o_data_valid), 32'h0);
            chk("rst_flight_rgb", 32'(o_fog_rgb), 32'h0);
            idle(1);
        end
        chk("rst_flight_dv3", 32'(o_data_valid), 32'h0);

        // Frame counter: 1920x4 valid pixels, then empty frames
        cyc(1'b0, 24'h0, 8'd0, 24'hF0F0F0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
        for (int i = 0; i < 7680; i++)
            cyc(1'b0, 24'($urandom()), 8'($urandom()), 24'($urandom()), (i % 1920) == 0,
                1'b0, 1'b1, 1'b0, 24'h0);
        cyc(1'b0, 24'h0, 8'd0, 24'hF0F0F0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
        chk("frame_7680", 32'(o_frame_pix_cnt), 32'd7680);
        for (int k = 0; k < 2; k++) begin
            idle(4);
            cyc(1'b0, 24'h0, 8'd0, 24'hF0F0F0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
            chk("frame_empty", 32'(o_frame_pix_cnt), 32'd0);
        end

        // Random traffic against the reference model
        vs_r = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) vs_r = ~vs_r;
            case ($urandom_range(0, 5))
                0:       t_r = 8'd0;
                1:       t_r = 8'd255;
                default: t_r = 8'($urandom());
            endcase
            cyc($urandom_range(0, 999) == 0, 24'($urandom()), t_r, 24'($urandom()),
                1'($urandom()), vs_r, $urandom_range(0, 3) != 0, 1'b0, 24'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
